// File: rtl/shared_drv_arb_if.sv
// Request/data bundle and shared-line outputs for shared_drv_arb.
// master drives requests and data bits, slave returns grant, line data and status.
interface shared_drv_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] i;
  logic [NREQ-1:0] gnt;
  logic            q;
  logic            oe;
  logic            busy;

  modport master (output req, output i, input gnt, input q, input oe, input busy);
  modport slave  (input req, input i, output gnt, output q, output oe, output busy);
endinterface

// File: rtl/shared_drv_arb.sv
// Round-robin owner of one shared buffered line with a hold limit and a dead TURN cycle.
// Grant 1 cycle after request from IDLE/TURN; non-owners wait, owner is forced off after HOLD_MAX.
module shared_drv_arb #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 3
) (
  input  logic            ck,
  input  logic            nrst,
  shared_drv_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

  state_t          state;
  logic [NREQ-1:0] gnt_r;
  logic            oe_r;
  logic            busy_r;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last;

  logic            sel_vld;
  logic [IW-1:0]   sel_idx;
  logic [NREQ-1:0] sel_oh;
  logic            release_own;

  // Search starts just past the previous owner, so that owner ranks last.
  always_comb begin : rr_pick
    logic [IW-1:0] cand;
    sel_vld = 1'b0;
    sel_idx = last;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!sel_vld && bus.req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    sel_oh          = '0;
    sel_oh[sel_idx] = 1'b1;
  end

  // last always holds the current owner while in GRANT.
  assign release_own = !bus.req[last] ||
                       ((cnt == HOLD_LIM) && (|(bus.req & ~gnt_r)));

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      gnt_r  <= '0;
      oe_r   <= 1'b0;
      busy_r <= 1'b0;
      cnt    <= '0;
      last   <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE, TURN: begin
          if (sel_vld) begin
            state  <= GRANT;
            gnt_r  <= sel_oh;
            oe_r   <= 1'b1;
            busy_r <= 1'b1;
            cnt    <= CW'(1);
            last   <= sel_idx;
          end else begin
            state  <= IDLE;
            gnt_r  <= '0;
            oe_r   <= 1'b0;
            busy_r <= 1'b0;
            cnt    <= '0;
          end
        end
        GRANT: begin
          if (release_own) begin
            state  <= TURN;
            gnt_r  <= '0;
            oe_r   <= 1'b0;
            busy_r <= 1'b1;
            cnt    <= '0;
          end else if (cnt != HOLD_LIM) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          gnt_r  <= '0;
          oe_r   <= 1'b0;
          busy_r <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.oe   = oe_r;
  assign bus.busy = busy_r;
  assign bus.q    = |(gnt_r & bus.i);
endmodule

// File: tb/tb_shared_drv_arb.sv
// Bench for shared_drv_arb: vector table, directed corner sequences and random traffic
// checked against an owner/hold-count reference model.
module tb_shared_drv_arb;
  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 3;

  logic ck;
  logic nrst;

  shared_drv_arb_if #(.NREQ(NREQ)) bus ();

  shared_drv_arb #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .ck   (ck),
    .nrst (nrst),
    .bus  (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the line, how long they have held it, and whether
  // the current cycle is the mandatory dead cycle after a release.
  int m_owner;
  int m_held;
  bit m_gap;
  int m_last;
  logic [NREQ-1:0] prev_gnt;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] i;
    logic [3:0] gnt;
    logic       oe;
    logic       q;
    logic       busy;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_held   = 0;
    m_gap    = 0;
    m_last   = NREQ - 1;
    prev_gnt = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r);
    bit found;
    bit others;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int k = 0; k < NREQ; k++)
        if (k != m_owner && r[k]) others = 1'b1;
      if (!r[m_owner] || (m_held == HOLD_MAX && others)) begin
        m_owner = -1;
        m_gap   = 1;
        m_held  = 0;
      end else if (m_held < HOLD_MAX) begin
        m_held++;
      end
    end else begin
      m_gap = 0;
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (!found && r[c]) begin
          found   = 1;
          m_owner = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, check at the next fall.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] iv);
    logic [NREQ-1:0] exp_gnt;
    logic            exp_oe;
    logic            exp_q;
    logic            exp_busy;
    bit              gap_ok;
    bus.req = r;
    bus.i   = iv;
    @(posedge ck);
    model_step(r);
    @(negedge ck);
    exp_gnt  = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    exp_oe   = (m_owner >= 0);
    exp_q    = (m_owner >= 0) ? iv[m_owner] : 1'b0;
    exp_busy = (m_owner >= 0) || m_gap;
    check("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("model_oe_q_busy", {29'd0, bus.oe, bus.q, bus.busy}, {29'd0, exp_oe, exp_q, exp_busy});
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    check("oe_eq_or_gnt", {31'd0, bus.oe}, {31'd0, |bus.gnt});
    gap_ok = (prev_gnt == '0) || (bus.gnt == '0) || (bus.gnt == prev_gnt);
    check("turn_between_owners", {31'd0, gap_ok}, 32'd1);
    prev_gnt = bus.gnt;
  endtask

  // Called at a falling edge; reset must clear outputs without any clock edge.
  task automatic do_reset(input string name);
    nrst = 1'b0;
    #1;
    check(name, {25'd0, bus.gnt, bus.oe, bus.q, bus.busy}, 32'd0);
    model_reset();
    @(negedge ck);
    @(negedge ck);
    nrst = 1'b1;
  endtask

  logic [NREQ-1:0] rnd_req;

  initial begin
    tbl[0]  = {4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1};
    tbl[1]  = {4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1};
    tbl[2]  = {4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1};
    tbl[3]  = {4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1};
    tbl[4]  = {4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1};
    tbl[5]  = {4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = {4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1};
    tbl[8]  = {4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[9]  = {4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[10] = {4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1};
    tbl[11] = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[12] = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[13] = {4'b0011, 4'b0011, 4'b0001, 1'b1, 1'b1, 1'b1};
    tbl[14] = {4'b0011, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1};
    tbl[15] = {4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1};
    tbl[16] = {4'b0011, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[17] = {4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1};
    tbl[18] = {4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[19] = {4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1};
    tbl[20] = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    tbl[21] = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};

    nrst    = 1'b1;
    bus.req = '0;
    bus.i   = '0;
    #2;
    do_reset("reset_state");

    // Single request, release, handover and forced release from a fresh reset.
    for (int v = 0; v < 22; v++) begin
      cycle(tbl[v].req, tbl[v].i);
      check($sformatf("tbl_row%0d", v),
            {25'd0, bus.gnt, bus.oe, bus.q, bus.busy},
            {25'd0, tbl[v].gnt, tbl[v].oe, tbl[v].q, tbl[v].busy});
    end

    // All requesting: owners 0,1,2,3,0 for HOLD_MAX cycles each, one dead cycle between.
    do_reset("reset_before_rotation");
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < HOLD_MAX; c++) begin
        cycle(4'b1111, 4'($urandom));
        check($sformatf("rotation_owner%0d_c%0d", o, c), 32'(bus.gnt), 32'(1 << (o % NREQ)));
      end
      cycle(4'b1111, 4'($urandom));
      check($sformatf("rotation_turn%0d", o), 32'(bus.gnt), 32'd0);
    end

    // Lone requester keeps the line past HOLD_MAX with no dead cycle.
    do_reset("reset_before_saturation");
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0010, 4'($urandom));
      check($sformatf("saturate_c%0d", c), 32'(bus.gnt), 32'b0010);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset("reset_before_midgrant");
    cycle(4'b0100, 4'b0100);
    cycle(4'b0100, 4'b0100);
    check("midgrant_owner", 32'(bus.gnt), 32'b0100);
    #2;
    do_reset("reset_midgrant_async");

    // Random traffic: each request bit toggles with probability 1/4 per cycle.
    rnd_req = '0;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(3) == 0) rnd_req[b] = ~rnd_req[b];
      cycle(rnd_req, 4'($urandom));
      if (n == 300) begin
        bus.req = '0;
        do_reset("reset_random_mid");
        rnd_req = '0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shared_drv_arb.md
SHARED_DRV_ARB -- requirements
Module: shared_drv_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one buffered output line; legal range 2..8.
REQ-002 Parameter HOLD_MAX, default 3: maximum consecutive grant cycles while another requester waits; legal range 1..255.
REQ-003 Port ck  input  1: single clock; all state updates occur on the rising edge.
REQ-004 Port nrst  input  1: reset, asynchronous, active-low.
REQ-005 Port req  input  NREQ: per-requester request; a requester holds it high for as long as it wants the line.
REQ-006 Port i  input  NREQ: per-requester data bit to drive onto the shared line.
REQ-007 Port gnt  output  NREQ: registered one-hot grant, or all-zero.
REQ-008 Port q  output  1: shared line data, equal to i[owner] when oe=1, else 0 (combinational from i and registered state).
REQ-009 Port oe  output  1: registered drive enable for the shared buffer, equal to OR of gnt.
REQ-010 Port busy  output  1: registered, high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT, TURN.
REQ-012 IDLE: gnt=0, oe=0; if any req bit is high, select an owner and enter GRANT on the next edge.
REQ-013 Owner selection SHALL be round-robin: search from index (last+1) mod NREQ upward with wrap; first high req wins; last is updated to the new owner.
REQ-014 Request-to-grant latency SHALL be exactly 1 cycle from IDLE (req high at edge n -> gnt high after edge n).
REQ-015 GRANT: gnt[owner]=1, oe=1, q=i[owner]; hold counter is 1 in the first grant cycle and increments each further cycle, saturating at HOLD_MAX.
REQ-016 GRANT -> TURN when req[owner] is sampled low (voluntary release).
REQ-017 GRANT -> TURN when counter equals HOLD_MAX and any other req bit is high (forced release); the grant therefore lasts exactly HOLD_MAX cycles.
REQ-018 If counter equals HOLD_MAX and no other requester is pending, GRANT SHALL persist unchanged with counter saturated.
REQ-019 Voluntary release and hold expiry in the same cycle SHALL be treated as one release; the result is identical.
REQ-020 TURN SHALL last exactly one cycle with gnt=0, oe=0, q=0, so that two drivers are never enabled in adjacent cycles.
REQ-021 From TURN: if any req is high, select a new owner per REQ-013 and enter GRANT; otherwise enter IDLE.
REQ-022 A force-released owner that still requests SHALL compete normally; it has lowest priority because last equals its index.
REQ-023 Changes on req bits of non-owners during GRANT SHALL have no effect on gnt until the next selection.
REQ-024 gnt SHALL never have more than one bit set, and oe SHALL equal |gnt in every cycle.

Reset
REQ-025 While nrst=0: state=IDLE, gnt=0, oe=0, q=0, busy=0, counter=0, last=NREQ-1, applied asynchronously even in the middle of a grant.
REQ-026 After nrst deasserts, the first selection SHALL give requester 0 highest priority.

Verification (NREQ=4, HOLD_MAX=3)
REQ-027 Reset: assert nrst=0 mid-GRANT with gnt=0100 -> gnt=0000, oe=0, q=0, busy=0 immediately, before the next ck edge.
REQ-028 Single request: req=0100 at edge 0 -> gnt=0100, oe=1, q tracks i[2] from edge 1; drop req at edge 5 -> gnt=0000 (TURN) after edge 6, busy=0 after edge 7.
REQ-029 All request: req=1111 held after reset -> owners 0,1,2,3,0, each granted exactly 3 cycles, each separated by exactly one all-zero gnt cycle.
REQ-030 Saturation: only req=0010 held for 10 cycles -> gnt=0010 continuously, with no TURN cycle inserted.
REQ-031 Handover: owner 1 drops req in the same cycle that req[3] rises -> next cycle is TURN, then gnt=1000 for the following cycle.
REQ-032 Checkers on every cycle: gnt is one-hot or zero; oe equals |gnt; no owner-to-owner transition occurs without an intervening TURN cycle.
